// File: rtl/lc3_mem_ctrl.sv
// LC-3 word memory with a programmable wait-state access handshake and a side preload port.
// Each access runs IDLE (sample) -> BUSY x WAIT_CYCLES -> DONE (complete pulse) -> IDLE.
module lc3_mem_ctrl #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int DEPTH_LOG2  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] din,
  input  logic              rd,
  output logic [DATA_W-1:0] dout,
  output logic              complete,
  output logic              busy,
  input  logic              prog_en,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [1:0]        fsm_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  take;
  logic [ADDR_W-1:0]     a_q;
  logic [DATA_W-1:0]     d_q;
  logic                  wr_q;
  logic [ADDR_W-1:0]     c_addr;
  logic [DATA_W-1:0]     c_data;
  logic                  c_wr;
  logic                  enter_done;
  logic [DEPTH_LOG2-1:0] c_idx;
  logic [DEPTH_LOG2-1:0] p_idx;
  logic                  unused_hi;

  logic [DATA_W-1:0] mem [2**DEPTH_LOG2];

  // Handshake: the bus is taken on any edge where the FSM is IDLE and prog_en=0;
  // there is no request strobe. complete is a one-cycle done strobe (state DONE),
  // and busy covers BUSY and DONE. The core advances on the complete edge.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    take     = 1'b0;
    case (state)
      IDLE: begin
        if (!prog_en) begin
          take = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_nx = DONE;
          end else begin
            state_nx = BUSY;
            cnt_nx   = CNT_INIT;
          end
        end
      end
      BUSY: begin
        if (cnt == 4'd0) state_nx = DONE;
        else             cnt_nx   = cnt - 4'd1;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // With no wait states the commit happens on the sampling edge, so use the live bus.
  always_comb begin
    c_addr = a_q;
    c_data = d_q;
    c_wr   = wr_q;
    if (state == IDLE) begin
      c_addr = addr;
      c_data = din;
      c_wr   = (rd === 1'b0);
    end
  end

  assign enter_done = (state_nx == DONE) && (state != DONE);
  assign c_idx      = c_addr[DEPTH_LOG2-1:0];
  assign p_idx      = prog_addr[DEPTH_LOG2-1:0];
  assign unused_hi  = ^{c_addr[ADDR_W-1:DEPTH_LOG2], prog_addr[ADDR_W-1:DEPTH_LOG2]};

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
      a_q   <= '0;
      d_q   <= '0;
      wr_q  <= 1'b0;
      dout  <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (take) begin
        a_q  <= addr;
        d_q  <= din;
        wr_q <= (rd === 1'b0);
      end
      if (enter_done && !c_wr) dout <= mem[c_idx];
    end
  end

  // Array is never cleared; preload is ordered last so it wins an index collision.
  always_ff @(posedge clock) begin
    if (reset && enter_done && c_wr) mem[c_idx] <= c_data;
    if (prog_en) mem[p_idx] <= prog_data;
  end

  assign complete  = (state == DONE);
  assign busy      = (state != IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_lc3_mem_ctrl.sv
// Directed bench for lc3_mem_ctrl: one instance with 2 wait states, one with none.
module tb_lc3_mem_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] addr, din, dout, prog_addr, prog_data;
  logic        rd, complete, busy, prog_en;
  logic [1:0]  fsm_state;
  logic [15:0] addr0, din0, dout0, prog_addr0, prog_data0;
  logic        rd0, complete0, busy0, prog_en0;
  logic [1:0]  fsm_state0;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12), .WAIT_CYCLES(2)) dut (
    .clock(clock), .reset(reset), .addr(addr), .din(din), .rd(rd), .dout(dout),
    .complete(complete), .busy(busy), .prog_en(prog_en), .prog_addr(prog_addr),
    .prog_data(prog_data), .fsm_state(fsm_state)
  );

  lc3_mem_ctrl #(.DATA_W(16), .ADDR_W(16), .DEPTH_LOG2(12), .WAIT_CYCLES(0)) dut0 (
    .clock(clock), .reset(reset), .addr(addr0), .din(din0), .rd(rd0), .dout(dout0),
    .complete(complete0), .busy(busy0), .prog_en(prog_en0), .prog_addr(prog_addr0),
    .prog_data(prog_data0), .fsm_state(fsm_state0)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL wait_idle: busy=%b after %0d cycles, want 0", busy, n);
    end
  endtask

  task automatic preload(input logic [15:0] a, input logic [15:0] d);
    prog_en   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_en   = 1'b0;
  endtask

  // Presents one request in IDLE; returns edges until complete and leaves the FSM in IDLE.
  task automatic access(input logic r, input logic [15:0] a, input logic [15:0] d,
                        output int lat);
    rd   = r;
    addr = a;
    din  = d;
    lat  = 0;
    do begin
      tick();
      lat++;
    end while (complete !== 1'b1 && lat < 20);
    tick();
    rd = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset_state();
    total += 6;
    if (dout !== 16'h0000)  begin bad++; $display("FAIL rst_dout: got %h want 0000", dout); end
    if (complete !== 1'b0)  begin bad++; $display("FAIL rst_complete: got %b want 0", complete); end
    if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    if (dout0 !== 16'h0000) begin bad++; $display("FAIL rst_dout0: got %h want 0000", dout0); end
    if (complete0 !== 1'b0) begin bad++; $display("FAIL rst_complete0: got %b want 0", complete0); end
    if (busy0 !== 1'b0)     begin bad++; $display("FAIL rst_busy0: got %b want 0", busy0); end
  endtask

  task automatic test_read_latency();
    int   lat;
    logic exp_c [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic exp_b [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] exp_d [4] = '{16'h0000, 16'h0000, 16'h1261, 16'h1261};
    wait_idle();
    preload(16'h0100, 16'h0000);
    preload(16'h3000, 16'h1261);
    preload(16'h3005, 16'h0000);
    preload(16'h3010, 16'h0000);
    preload(16'h3020, 16'h0000);
    preload(16'h3030, 16'h1111);
    access(1'b1, 16'h0100, 16'h0000, lat);
    total += 2;
    if (lat != 3)          begin bad++; $display("FAIL lat_read0100: got %0d want 3", lat); end
    if (dout !== 16'h0000) begin bad++; $display("FAIL dout_read0100: got %h want 0000", dout); end
    rd   = 1'b1;
    addr = 16'h3000;
    for (int i = 0; i < 4; i++) begin
      tick();
      total += 3;
      if (complete !== exp_c[i]) begin
        bad++; $display("FAIL lat_complete e+%0d: got %b want %b", i + 1, complete, exp_c[i]);
      end
      if (busy !== exp_b[i]) begin
        bad++; $display("FAIL lat_busy e+%0d: got %b want %b", i + 1, busy, exp_b[i]);
      end
      if (dout !== exp_d[i]) begin
        bad++; $display("FAIL lat_dout e+%0d: got %h want %h", i + 1, dout, exp_d[i]);
      end
    end
  endtask

  task automatic test_write_read();
    int lat;
    access(1'b0, 16'h3005, 16'hBEEF, lat);
    total += 2;
    if (lat != 3)          begin bad++; $display("FAIL lat_write: got %0d want 3", lat); end
    if (dout !== 16'h1261) begin bad++; $display("FAIL write_dout_held: got %h want 1261", dout); end
    access(1'b1, 16'h3005, 16'h0000, lat);
    total += 1;
    if (dout !== 16'hBEEF) begin bad++; $display("FAIL read_back_3005: got %h want beef", dout); end
  endtask

  task automatic test_alias();
    int lat;
    access(1'b1, 16'h0005, 16'h0000, lat);
    total += 1;
    if (dout !== 16'hBEEF) begin bad++; $display("FAIL alias_0005: got %h want beef", dout); end
    access(1'b0, 16'hF007, 16'h7777, lat);
    access(1'b1, 16'h0007, 16'h0000, lat);
    total += 1;
    if (dout !== 16'h7777) begin bad++; $display("FAIL alias_f007: got %h want 7777", dout); end
  endtask

  task automatic test_reset_midstream();
    int lat;
    rd   = 1'b1;
    addr = 16'h0005;
    tick();
    total += 1;
    if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    reset = 1'b0;
    #1;
    total += 3;
    if (complete !== 1'b0) begin bad++; $display("FAIL mid_complete_now: got %b want 0", complete); end
    if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy_now: got %b want 0", busy); end
    if (dout !== 16'h0000) begin bad++; $display("FAIL mid_dout_now: got %h want 0000", dout); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total += 2;
      if (complete !== 1'b0) begin bad++; $display("FAIL mid_complete c%0d: got %b want 0", i, complete); end
      if (busy !== 1'b0)     begin bad++; $display("FAIL mid_busy c%0d: got %b want 0", i, busy); end
    end
    reset = 1'b1;
    access(1'b1, 16'h3000, 16'h0000, lat);
    total += 2;
    if (lat != 3)          begin bad++; $display("FAIL mid_first_lat: got %0d want 3", lat); end
    if (dout !== 16'h1261) begin bad++; $display("FAIL mid_first_dout: got %h want 1261", dout); end
  endtask

  task automatic test_reset_abort();
    int lat;
    rd   = 1'b0;
    addr = 16'h3010;
    din  = 16'h1234;
    tick();
    total += 1;
    if (busy !== 1'b1) begin bad++; $display("FAIL abort_busy: got %b want 1", busy); end
    reset = 1'b0;
    rd    = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      total += 1;
      if (complete !== 1'b0) begin bad++; $display("FAIL abort_complete c%0d: got %b want 0", i, complete); end
    end
    reset = 1'b1;
    access(1'b1, 16'h3010, 16'h0000, lat);
    total += 2;
    if (lat != 3)          begin bad++; $display("FAIL abort_read_lat: got %0d want 3", lat); end
    if (dout !== 16'h0000) begin bad++; $display("FAIL abort_read_3010: got %h want 0000", dout); end
  endtask

  task automatic test_back_to_back();
    int lat;
    // CPU write and preload land on index 0x020 on the same edge.
    rd = 1'b0; addr = 16'h3020; din = 16'hAAAA;
    tick();
    tick();
    prog_en = 1'b1; prog_addr = 16'h0020; prog_data = 16'h5555;
    tick();
    prog_en = 1'b0;
    rd = 1'b1;
    total += 1;
    if (complete !== 1'b1) begin bad++; $display("FAIL coll_wr_complete: got %b want 1", complete); end
    tick();
    access(1'b1, 16'h3020, 16'h0000, lat);
    total += 1;
    if (dout !== 16'h5555) begin bad++; $display("FAIL coll_wr_winner: got %h want 5555", dout); end
    // Read commit on the edge a preload rewrites the same word.
    rd = 1'b1; addr = 16'h3030;
    tick();
    tick();
    prog_en = 1'b1; prog_addr = 16'h3030; prog_data = 16'h2222;
    tick();
    prog_en = 1'b0;
    total += 2;
    if (complete !== 1'b1) begin bad++; $display("FAIL coll_rd_complete: got %b want 1", complete); end
    if (dout !== 16'h1111) begin bad++; $display("FAIL coll_rd_old: got %h want 1111", dout); end
    tick();
    access(1'b1, 16'h3030, 16'h0000, lat);
    total += 1;
    if (dout !== 16'h2222) begin bad++; $display("FAIL coll_rd_new: got %h want 2222", dout); end
  endtask

  task automatic test_wait0();
    logic [15:0] adr [4] = '{16'h0010, 16'h0011, 16'hF012, 16'h0013};
    logic [15:0] val [4] = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
    logic [15:0] exp_d;
    logic        exp_c;
    prog_en0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      prog_addr0 = 16'h0010 + 16'(i);
      prog_data0 = val[i];
      tick();
      total += 1;
      if (complete0 !== 1'b0) begin bad++; $display("FAIL w0_blocked c%0d: got %b want 0", i, complete0); end
    end
    prog_en0 = 1'b0;
    rd0      = 1'b1;
    addr0    = adr[0];
    exp_d    = val[0];
    for (int i = 0; i < 8; i++) begin
      tick();
      exp_c = (i % 2 == 0);
      if (exp_c) exp_d = val[i / 2];
      total += 2;
      if (complete0 !== exp_c) begin bad++; $display("FAIL w0_complete c%0d: got %b want %b", i, complete0, exp_c); end
      if (dout0 !== exp_d)     begin bad++; $display("FAIL w0_dout c%0d: got %h want %h", i, dout0, exp_d); end
      if (exp_c && i < 6) addr0 = adr[i / 2 + 1];
    end
  endtask

  // ---------------- sequence ----------------
  initial begin
    reset = 1'b1;
    rd = 1'b1; addr = 16'h0100; din = '0; prog_en = 1'b0; prog_addr = '0; prog_data = '0;
    rd0 = 1'b1; addr0 = '0; din0 = '0; prog_en0 = 1'b0; prog_addr0 = '0; prog_data0 = '0;
    #2 reset = 1'b0;
    repeat (3) tick();
    test_reset_state();
    reset = 1'b1;
    test_read_latency();
    test_write_read();
    test_alias();
    test_reset_midstream();
    test_reset_abort();
    test_back_to_back();
    test_wait0();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
